// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decrypt stage: one keystream byte per message byte, XORed with the ROM byte.
// Optional PRGA_CHAR_CHECK_EN aborts to a terminal FAIL state on a non lowercase/space plaintext byte.
module rc4_prga_decrypt #(
   parameter int MSG_LEN = 32,
   parameter int MSG_AW  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        s_q,
   output logic [7:0]        s_address,
   output logic [7:0]        s_data,
   output logic              s_wren,
   output logic [MSG_AW-1:0] rom_address,
   input  logic [7:0]        rom_q,
   output logic [MSG_AW-1:0] dec_address,
   output logic [7:0]        dec_data,
   output logic              dec_wren,
   output logic              done,
   output logic              invalid
);

`ifdef PRGA_CHAR_CHECK_EN
   typedef enum logic [4:0] {
      IDLE, INC_I, RD_SI, WAIT_SI, LATCH_SI, CALC_J, RD_SJ, WAIT_SJ, LATCH_SJ,
      WR_SI_J, WR_SJ_I, RD_F, WAIT_F, LATCH_F, WR_DEC, NEXT_K, DONE, FAIL
   } state_t;
`else
   typedef enum logic [4:0] {
      IDLE, INC_I, RD_SI, WAIT_SI, LATCH_SI, CALC_J, RD_SJ, WAIT_SJ, LATCH_SJ,
      WR_SI_J, WR_SJ_I, RD_F, WAIT_F, LATCH_F, WR_DEC, NEXT_K, DONE
   } state_t;
`endif

   localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

   state_t            state;
   state_t            state_next;
   logic [7:0]        i;
   logic [7:0]        j;
   logic [MSG_AW-1:0] k;
   logic [7:0]        si;
   logic [7:0]        sj;
   logic [7:0]        f;
   logic [7:0]        enc;
   logic [7:0]        plain;
   logic [7:0]        f_index;

   assign plain   = f ^ enc;
   // The swap preserves si+sj, so the latched pre-swap values address the keystream byte.
   assign f_index = si + sj;

`ifdef PRGA_CHAR_CHECK_EN
   logic char_ok;
   assign char_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      s_address   = i;
      s_data      = 8'h00;
      s_wren      = 1'b0;
      rom_address = k;
      dec_address = k;
      dec_data    = 8'h00;
      dec_wren    = 1'b0;
      case (state)
         IDLE:     if (start) state_next = INC_I;
         INC_I:    state_next = RD_SI;
         RD_SI:    state_next = WAIT_SI;
         WAIT_SI:  state_next = LATCH_SI;
         LATCH_SI: state_next = CALC_J;
         CALC_J:   state_next = RD_SJ;
         RD_SJ: begin
            s_address  = j;
            state_next = WAIT_SJ;
         end
         WAIT_SJ: begin
            s_address  = j;
            state_next = LATCH_SJ;
         end
         LATCH_SJ: begin
            s_address  = j;
            state_next = WR_SI_J;
         end
         WR_SI_J: begin
            s_address  = j;
            s_data     = si;
            s_wren     = 1'b1;
            state_next = WR_SJ_I;
         end
         WR_SJ_I: begin
            s_data     = sj;
            s_wren     = 1'b1;
            state_next = RD_F;
         end
         RD_F: begin
            s_address  = f_index;
            state_next = WAIT_F;
         end
         WAIT_F: begin
            s_address  = f_index;
            state_next = LATCH_F;
         end
         LATCH_F: begin
            s_address  = f_index;
            state_next = WR_DEC;
         end
         WR_DEC: begin
            dec_data = plain;
`ifdef PRGA_CHAR_CHECK_EN
            if (char_ok) begin
               dec_wren   = 1'b1;
               state_next = NEXT_K;
            end else begin
               state_next = FAIL;
            end
`else
            dec_wren   = 1'b1;
            state_next = NEXT_K;
`endif
         end
         NEXT_K:   state_next = (k == LAST_K) ? DONE : INC_I;
         DONE:     state_next = DONE;
`ifdef PRGA_CHAR_CHECK_EN
         FAIL:     state_next = FAIL;
`endif
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i   <= 8'h00;
         j   <= 8'h00;
         k   <= '0;
         si  <= 8'h00;
         sj  <= 8'h00;
         f   <= 8'h00;
         enc <= 8'h00;
      end else begin
         case (state)
            INC_I:    i  <= i + 8'd1;
            LATCH_SI: si <= s_q;
            CALC_J:   j  <= j + si;
            LATCH_SJ: sj <= s_q;
            LATCH_F: begin
               f   <= s_q;
               enc <= rom_q;
            end
            NEXT_K:   if (k != LAST_K) k <= k + MSG_AW'(1);
            default: ;
         endcase
      end
   end

   // Status flags are registered, so they rise one edge after the terminal state is entered.
`ifdef PRGA_CHAR_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         done    <= (state == DONE) || (state == FAIL);
         invalid <= (state == FAIL);
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done <= 1'b0;
      end else begin
         done <= (state == DONE);
      end
   end

   assign invalid = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: RAM/ROM models with 2-cycle read latency and a plain RC4 reference model.
module tb_rc4_prga_decrypt;

   localparam int LEN = 4;
   localparam int AW  = 5;
`ifdef PRGA_CHAR_CHECK_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    s_q;
   logic [7:0]    s_address;
   logic [7:0]    s_data;
   logic          s_wren;
   logic [AW-1:0] rom_address;
   logic [7:0]    rom_q;
   logic [AW-1:0] dec_address;
   logic [7:0]    dec_data;
   logic          dec_wren;
   logic          done;
   logic          invalid;

   rc4_prga_decrypt #(.MSG_LEN(LEN), .MSG_AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .s_q(s_q), .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
      .rom_address(rom_address), .rom_q(rom_q),
      .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren),
      .done(done), .invalid(invalid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  smem   [256];
   logic [7:0]  s_init [256];
   logic [7:0]  rom    [32];
   logic [7:0]  s_p1;
   logic [7:0]  rom_p1;
   logic        load_req = 1'b0;

   logic [15:0] exp_s[$];
   logic [15:0] exp_dec[$];
   logic [15:0] s_log[$];
   logic [15:0] dec_log[$];
   bit          exp_fail;
   int          exp_edges;

   logic [15:0] lit_s   [8] = '{16'h0101, 16'h0101, 16'h0302, 16'h0203,
                                16'h0502, 16'h0305, 16'h0904, 16'h0409};
   logic [7:0]  lit_zero[4] = '{8'h02, 8'h05, 8'h07, 8'h0D};
   logic [7:0]  lit_aced[4] = '{8'h61, 8'h63, 8'h65, 8'h64};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // S RAM and ROM: address registered twice, so data is valid in the third cycle.
   always @(posedge clk) begin
      s_p1   <= smem[s_address];
      s_q    <= s_p1;
      rom_p1 <= rom[rom_address];
      rom_q  <= rom_p1;
      if (load_req) begin
         for (int x = 0; x < 256; x++) smem[x] <= s_init[x];
      end else if (s_wren) begin
         smem[s_address] <= s_data;
      end
   end

   always @(negedge clk) begin
      logic [16:0] e;
      if (!reset) begin
         if (s_wren) begin
            s_log.push_back({s_address, s_data});
            e = 17'h0;
            if (exp_s.size() > 0) e = {1'b1, exp_s.pop_front()};
            check("s_write", {15'h0, 1'b1, s_address, s_data}, {15'h0, e});
         end
         if (dec_wren) begin
            dec_log.push_back({8'(dec_address), dec_data});
            e = 17'h0;
            if (exp_dec.size() > 0) e = {1'b1, exp_dec.pop_front()};
            check("dec_write", {15'h0, 1'b1, 8'(dec_address), dec_data}, {15'h0, e});
         end
`ifndef PRGA_CHAR_CHECK_EN
         check("invalid_low", {31'h0, invalid}, 32'h0);
`endif
      end
   end

   task automatic build_model();
      logic [7:0] s [256];
      logic [7:0] i8, j8, t, fi, p;
      for (int x = 0; x < 256; x++) s[x] = s_init[x];
      exp_s.delete();
      exp_dec.delete();
      exp_fail  = 1'b0;
      exp_edges = 15 * LEN + 1;
      i8 = 8'h00;
      j8 = 8'h00;
      for (int kk = 0; kk < LEN; kk++) begin
         i8 = i8 + 8'd1;
         j8 = j8 + s[i8];
         exp_s.push_back({j8, s[i8]});
         exp_s.push_back({i8, s[j8]});
         t = s[i8]; s[i8] = s[j8]; s[j8] = t;
         fi = s[i8] + s[j8];
         p  = s[fi] ^ rom[kk];
         if (FEAT && !(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) begin
            exp_fail  = 1'b1;
            exp_edges = 15 * kk + 15;
            break;
         end
         exp_dec.push_back({8'(kk), p});
      end
   endtask

   task automatic load(input int pat);
      for (int x = 0; x < 256; x++) s_init[x] = (pat == 2) ? 8'(255 - x) : 8'(x);
      for (int x = 0; x < 32; x++) begin
         case (pat)
            1:       rom[x] = 8'h00;
            2:       rom[x] = 8'(x * 8'h35 + 7);
            default: rom[x] = 8'h00;
         endcase
      end
      if (pat == 1) begin
         rom[0] = 8'h63; rom[1] = 8'h66; rom[2] = 8'h62; rom[3] = 8'h69;
      end
      @(negedge clk);
      load_req = 1'b1;
      @(posedge clk);
      #1 load_req = 1'b0;
      build_model();
      s_log.delete();
      dec_log.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_msg(input string tag, input bit drop_start);
      int n;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 400) begin
         @(posedge clk);
         n++;
         #1;
         if (drop_start && n == 3) start = 1'b0;
         if (done) break;
      end
      check({tag, "_done_edges"}, n, exp_edges);
      check({tag, "_invalid"}, {31'h0, invalid}, {31'h0, exp_fail});
      repeat (10) @(posedge clk);
      #1;
      check({tag, "_done_held"}, {31'h0, done}, 32'h1);
      check({tag, "_s_missing"}, exp_s.size(), 0);
      check({tag, "_dec_missing"}, exp_dec.size(), 0);
      start = 1'b0;
   endtask

   task automatic check_literals_zero(input string tag);
      check({tag, "_s_count"}, s_log.size(), 8);
      for (int n = 0; n < 8; n++)
         check($sformatf("%s_s_lit%0d", tag, n), (n < s_log.size()) ? s_log[n] : 16'h0, lit_s[n]);
      check({tag, "_dec_count"}, dec_log.size(), 4);
      for (int n = 0; n < 4; n++)
         check($sformatf("%s_dec_lit%0d", tag, n), (n < dec_log.size()) ? dec_log[n] : 16'h0,
               {8'(n), lit_zero[n]});
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_s_address"}, s_address, 0);
      check({tag, "_s_data"}, s_data, 0);
      check({tag, "_s_wren"}, s_wren, 0);
      check({tag, "_rom_address"}, rom_address, 0);
      check({tag, "_dec_address"}, dec_address, 0);
      check({tag, "_dec_data"}, dec_data, 0);
      check({tag, "_dec_wren"}, dec_wren, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_invalid"}, invalid, 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
      for (int x = 0; x < 32; x++) rom[x] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // Idle with start low: no writes, done stays low.
      repeat (20) begin
         @(negedge clk);
         check("idle_done", {31'h0, done}, 32'h0);
      end
      check("idle_s_writes", s_log.size(), 0);
      check("idle_dec_writes", dec_log.size(), 0);

      // Identity S, zero ROM.
      load(0);
      run_msg("zero", 1'b0);
`ifndef PRGA_CHAR_CHECK_EN
      check_literals_zero("zero");
`endif

      // Identity S, "aced" ciphertext, start dropped mid-run.
      do_reset();
      load(1);
      run_msg("aced", 1'b1);
      check("aced_dec_count", dec_log.size(), 4);
      for (int n = 0; n < 4; n++)
         check($sformatf("aced_lit%0d", n), (n < dec_log.size()) ? dec_log[n] : 16'h0,
               {8'(n), lit_aced[n]});

      // Reversed S with a ramp ciphertext, checked only against the model.
      do_reset();
      load(2);
      run_msg("rev", 1'b0);

      // Abort during WAIT_SJ of the third byte.
      do_reset();
      load(1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      repeat (36) @(posedge clk);
      #2;
      reset = 1'b1;
      start = 1'b0;
      #1;
      check_outputs_zero("abort");
      check("abort_s_left", exp_s.size(), 4);
      check("abort_dec_left", exp_dec.size(), 2);
      exp_s.delete();
      exp_dec.delete();
      s_log.delete();
      dec_log.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         check("abort_idle_done", {31'h0, done}, 32'h0);
      end
      check("abort_no_s_writes", s_log.size(), 0);
      check("abort_no_dec_writes", dec_log.size(), 0);

      // Restart from a freshly loaded S reproduces the first run.
      load(0);
      run_msg("rerun", 1'b0);
`ifndef PRGA_CHAR_CHECK_EN
      check_literals_zero("rerun");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
